// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port between I-cache refills and D-cache refills/write-backs, one transaction in flight.
// Latency: grant to memory request 1 cycle, response pulse 1 cycle after mem_r_valid/mem_b_valid.
// Backpressure: requesters hold valid until their single-cycle ready; memory stalls via mem_ar_ready/mem_aw_ready.
// Optional watchdog and error flag enabled by defining MEM_PORT_ARBITER_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_WIDTH     = 128,
    parameter int OFFSET_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ic_rreq_valid,
    output logic                    ic_rreq_ready,
    input  logic [ADDR_WIDTH-1:0]   ic_rreq_addr,
    output logic                    ic_rresp_valid,
    output logic [LINE_WIDTH-1:0]   ic_rresp_data,
    input  logic                    dc_rreq_valid,
    output logic                    dc_rreq_ready,
    input  logic [ADDR_WIDTH-1:0]   dc_rreq_addr,
    output logic                    dc_rresp_valid,
    output logic [LINE_WIDTH-1:0]   dc_rresp_data,
    input  logic                    dc_wreq_valid,
    output logic                    dc_wreq_ready,
    input  logic [ADDR_WIDTH-1:0]   dc_wreq_addr,
    input  logic [LINE_WIDTH-1:0]   dc_wreq_data,
    input  logic [LINE_WIDTH/8-1:0] dc_wreq_wmask,
    output logic                    dc_wresp_valid,
    output logic                    mem_ar_valid,
    input  logic                    mem_ar_ready,
    output logic [ADDR_WIDTH-1:0]   mem_ar_addr,
    input  logic                    mem_r_valid,
    input  logic [LINE_WIDTH-1:0]   mem_r_data,
    input  logic [1:0]              mem_r_resp,
    output logic                    mem_aw_valid,
    input  logic                    mem_aw_ready,
    output logic [ADDR_WIDTH-1:0]   mem_aw_addr,
    output logic [LINE_WIDTH-1:0]   mem_w_data,
    output logic [LINE_WIDTH/8-1:0] mem_w_wmask,
    input  logic                    mem_b_valid,
    input  logic [1:0]              mem_b_resp,
    output logic                    timeout_err
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_WAIT, WR_ADDR, WR_WAIT} state_t;
    typedef enum logic {OWN_IC, OWN_DC} owner_t;

    state_t                  state, state_nxt;
    owner_t                  owner;
    logic                    rr_dc;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE_WIDTH-1:0]   wdata_q;
    logic [LINE_WIDTH/8-1:0] wmask_q;
    logic                    wr_win, ic_win, dc_win;
    logic                    tmo_hit, rd_done, wr_done;

    // Write-backs always win; reads alternate via rr_dc (0 favours the I-cache).
    assign wr_win = (state == IDLE) && dc_wreq_valid;
    assign ic_win = (state == IDLE) && !dc_wreq_valid && ic_rreq_valid && (!dc_rreq_valid || !rr_dc);
    assign dc_win = (state == IDLE) && !dc_wreq_valid && dc_rreq_valid && (!ic_rreq_valid || rr_dc);

    assign dc_wreq_ready = wr_win;
    assign ic_rreq_ready = ic_win;
    assign dc_rreq_ready = dc_win;

    assign rd_done = (state == RD_WAIT) && (mem_r_valid || tmo_hit);
    assign wr_done = (state == WR_WAIT) && (mem_b_valid || tmo_hit);

    assign mem_ar_valid = (state == RD_ADDR);
    assign mem_aw_valid = (state == WR_ADDR);
    assign mem_ar_addr  = {addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
    assign mem_aw_addr  = {addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
    assign mem_w_data   = wdata_q;
    assign mem_w_wmask  = wmask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wr_win)                state_nxt = WR_ADDR;
                else if (ic_win || dc_win) state_nxt = RD_ADDR;
            end
            RD_ADDR: if (mem_ar_ready) state_nxt = RD_WAIT;
            RD_WAIT: if (rd_done)      state_nxt = IDLE;
            WR_ADDR: if (mem_aw_ready) state_nxt = WR_WAIT;
            WR_WAIT: if (wr_done)      state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner          <= OWN_IC;
            rr_dc          <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wmask_q        <= '0;
            ic_rresp_valid <= 1'b0;
            ic_rresp_data  <= '0;
            dc_rresp_valid <= 1'b0;
            dc_rresp_data  <= '0;
            dc_wresp_valid <= 1'b0;
        end else begin
            ic_rresp_valid <= 1'b0;
            dc_rresp_valid <= 1'b0;
            dc_wresp_valid <= 1'b0;
            if (wr_win) begin
                owner   <= OWN_DC;
                addr_q  <= dc_wreq_addr;
                wdata_q <= dc_wreq_data;
                wmask_q <= dc_wreq_wmask;
            end else if (ic_win) begin
                owner  <= OWN_IC;
                addr_q <= ic_rreq_addr;
                rr_dc  <= 1'b1;
            end else if (dc_win) begin
                owner  <= OWN_DC;
                addr_q <= dc_rreq_addr;
                rr_dc  <= 1'b0;
            end
            // A watchdog expiry delivers an all-zero line to the owner.
            if (rd_done) begin
                if (owner == OWN_IC) begin
                    ic_rresp_valid <= 1'b1;
                    ic_rresp_data  <= mem_r_valid ? mem_r_data : '0;
                end else begin
                    dc_rresp_valid <= 1'b1;
                    dc_rresp_data  <= mem_r_valid ? mem_r_data : '0;
                end
            end
            if (wr_done) dc_wresp_valid <= 1'b1;
        end
    end

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        in_wait, resp_now, err_q;
    logic        unused_bits;

    assign in_wait     = (state == RD_WAIT) || (state == WR_WAIT);
    assign resp_now    = ((state == RD_WAIT) && mem_r_valid) || ((state == WR_WAIT) && mem_b_valid);
    assign tmo_hit     = in_wait && !resp_now && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign timeout_err = err_q;
    assign unused_bits = ^addr_q[OFFSET_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            wait_cnt <= in_wait ? wait_cnt + 16'd1 : '0;
            if (tmo_hit)                                         err_q <= 1'b1;
            if ((state == RD_WAIT) && mem_r_valid && |mem_r_resp) err_q <= 1'b1;
            if ((state == WR_WAIT) && mem_b_valid && |mem_b_resp) err_q <= 1'b1;
        end
    end
`else
    logic unused_bits;

    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
    assign unused_bits = ^{mem_r_resp, mem_b_resp, addr_q[OFFSET_WIDTH-1:0]} ^ (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: drives after posedge, samples at negedge.
module tb_mem_port_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ic_rreq_valid, ic_rreq_ready;
    logic [31:0]  ic_rreq_addr;
    logic         ic_rresp_valid;
    logic [127:0] ic_rresp_data;
    logic         dc_rreq_valid, dc_rreq_ready;
    logic [31:0]  dc_rreq_addr;
    logic         dc_rresp_valid;
    logic [127:0] dc_rresp_data;
    logic         dc_wreq_valid, dc_wreq_ready;
    logic [31:0]  dc_wreq_addr;
    logic [127:0] dc_wreq_data;
    logic [15:0]  dc_wreq_wmask;
    logic         dc_wresp_valid;
    logic         mem_ar_valid, mem_ar_ready;
    logic [31:0]  mem_ar_addr;
    logic         mem_r_valid;
    logic [127:0] mem_r_data;
    logic [1:0]   mem_r_resp;
    logic         mem_aw_valid, mem_aw_ready;
    logic [31:0]  mem_aw_addr;
    logic [127:0] mem_w_data;
    logic [15:0]  mem_w_wmask;
    logic         mem_b_valid;
    logic [1:0]   mem_b_resp;
    logic         timeout_err;

    int n_chk  = 0;
    int n_fail = 0;
    int n_icr  = 0;
    int n_dcr  = 0;
    int n_wr   = 0;
    int n_ar   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_rreq_valid(ic_rreq_valid), .ic_rreq_ready(ic_rreq_ready), .ic_rreq_addr(ic_rreq_addr),
        .ic_rresp_valid(ic_rresp_valid), .ic_rresp_data(ic_rresp_data),
        .dc_rreq_valid(dc_rreq_valid), .dc_rreq_ready(dc_rreq_ready), .dc_rreq_addr(dc_rreq_addr),
        .dc_rresp_valid(dc_rresp_valid), .dc_rresp_data(dc_rresp_data),
        .dc_wreq_valid(dc_wreq_valid), .dc_wreq_ready(dc_wreq_ready), .dc_wreq_addr(dc_wreq_addr),
        .dc_wreq_data(dc_wreq_data), .dc_wreq_wmask(dc_wreq_wmask), .dc_wresp_valid(dc_wresp_valid),
        .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready), .mem_ar_addr(mem_ar_addr),
        .mem_r_valid(mem_r_valid), .mem_r_data(mem_r_data), .mem_r_resp(mem_r_resp),
        .mem_aw_valid(mem_aw_valid), .mem_aw_ready(mem_aw_ready), .mem_aw_addr(mem_aw_addr),
        .mem_w_data(mem_w_data), .mem_w_wmask(mem_w_wmask),
        .mem_b_valid(mem_b_valid), .mem_b_resp(mem_b_resp), .timeout_err(timeout_err)
    );

    // Handshake counters, used to prove each ready pulses once and no duplicate AR.
    always @(negedge clk) begin
        if (ic_rreq_ready) n_icr++;
        if (dc_rreq_ready) n_dcr++;
        if (dc_wreq_ready) n_wr++;
        if (mem_ar_valid && mem_ar_ready) n_ar++;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, {ic_rreq_ready, ic_rresp_valid, dc_rreq_ready, dc_rresp_valid,
                                 dc_wreq_ready, dc_wresp_valid, mem_ar_valid, mem_aw_valid, timeout_err}, '0);
        check_eq({tag, "_icd"}, ic_rresp_data, '0);
        check_eq({tag, "_dcd"}, dc_rresp_data, '0);
        check_eq({tag, "_wd"}, mem_w_data, '0);
        check_eq({tag, "_addr"}, {mem_ar_addr, mem_aw_addr, mem_w_wmask}, '0);
    endtask

    task automatic clear_inputs();
        ic_rreq_valid = 0; ic_rreq_addr = '0;
        dc_rreq_valid = 0; dc_rreq_addr = '0;
        dc_wreq_valid = 0; dc_wreq_addr = '0; dc_wreq_data = '0; dc_wreq_wmask = '0;
        mem_ar_ready = 0; mem_r_valid = 0; mem_r_data = '0; mem_r_resp = '0;
        mem_aw_ready = 0; mem_b_valid = 0; mem_b_resp = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] d;
        int s_icr, s_dcr, s_wr, s_ar;
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        check_all_zero("rst");
        rst_n = 1'b1;

        // I-cache read alone
        ic_rreq_valid = 1; ic_rreq_addr = 32'h0000_1234; mem_ar_ready = 1;
        @(negedge clk);
        check_eq("t1_ic_rdy", ic_rreq_ready, 1);
        check_eq("t1_dc_rdy", {dc_rreq_ready, dc_wreq_ready}, 0);
        step(); ic_rreq_valid = 0; ic_rreq_addr = '0;
        @(negedge clk);
        check_eq("t1_ar_vld", mem_ar_valid, 1);
        check_eq("t1_ar_addr", mem_ar_addr, 32'h0000_1230);
        step(); mem_ar_ready = 0; mem_r_valid = 1; mem_r_data = {16{8'hA5}};
        @(negedge clk);
        check_eq("t1_ar_drop", mem_ar_valid, 0);
        check_eq("t1_no_early", ic_rresp_valid, 0);
        step(); mem_r_valid = 0; mem_r_data = '0;
        @(negedge clk);
        check_eq("t1_rresp_vld", ic_rresp_valid, 1);
        check_eq("t1_rresp_dat", ic_rresp_data, {16{8'hA5}});
        check_eq("t1_dc_quiet", dc_rresp_valid, 0);
        step();
        @(negedge clk);
        check_eq("t1_pulse_end", ic_rresp_valid, 0);
        check_eq("t1_data_hold", ic_rresp_data, {16{8'hA5}});

        // All three requesters valid together
        do_reset();
        s_icr = n_icr; s_dcr = n_dcr; s_wr = n_wr;
        dc_wreq_valid = 1; dc_wreq_addr = 32'h0000_2008; dc_wreq_data = {4{32'hDEAD_BEEF}}; dc_wreq_wmask = 16'hFFFF;
        ic_rreq_valid = 1; ic_rreq_addr = 32'h0000_3004;
        dc_rreq_valid = 1; dc_rreq_addr = 32'h0000_4010;
        mem_aw_ready = 1; mem_ar_ready = 1;
        @(negedge clk);
        check_eq("t2_rdy0", {dc_wreq_ready, ic_rreq_ready, dc_rreq_ready}, 3'b100);
        step(); dc_wreq_valid = 0;
        @(negedge clk);
        check_eq("t2_aw_vld", {mem_aw_valid, mem_ar_valid}, 2'b10);
        check_eq("t2_aw_addr", mem_aw_addr, 32'h0000_2000);
        check_eq("t2_w_data", mem_w_data, {4{32'hDEAD_BEEF}});
        check_eq("t2_w_mask", mem_w_wmask, 16'hFFFF);
        check_eq("t2_rdy_busy", {dc_wreq_ready, ic_rreq_ready, dc_rreq_ready}, 0);
        step(); mem_b_valid = 1;
        @(negedge clk);
        check_eq("t2_aw_drop", mem_aw_valid, 0);
        step(); mem_b_valid = 0;
        @(negedge clk);
        check_eq("t2_wresp", dc_wresp_valid, 1);
        check_eq("t2_rdy1", {dc_wreq_ready, ic_rreq_ready, dc_rreq_ready}, 3'b010);
        step(); ic_rreq_valid = 0;
        @(negedge clk);
        check_eq("t2_ic_ar_addr", mem_ar_addr, 32'h0000_3000);
        step(); mem_r_valid = 1; mem_r_data = {4{32'h1111_0001}};
        step(); mem_r_valid = 0;
        @(negedge clk);
        check_eq("t2_ic_resp", {ic_rresp_valid, dc_rresp_valid, dc_wresp_valid}, 3'b100);
        check_eq("t2_ic_data", ic_rresp_data, {4{32'h1111_0001}});
        check_eq("t2_rdy2", {dc_wreq_ready, ic_rreq_ready, dc_rreq_ready}, 3'b001);
        step(); dc_rreq_valid = 0;
        @(negedge clk);
        check_eq("t2_dc_ar_addr", mem_ar_addr, 32'h0000_4010);
        step(); mem_r_valid = 1; mem_r_data = {4{32'h2222_0002}};
        step(); mem_r_valid = 0;
        @(negedge clk);
        check_eq("t2_dc_resp", {ic_rresp_valid, dc_rresp_valid}, 2'b01);
        check_eq("t2_dc_data", dc_rresp_data, {4{32'h2222_0002}});
        step();
        check_eq("t2_wr_once", n_wr - s_wr, 1);
        check_eq("t2_ic_once", n_icr - s_icr, 1);
        check_eq("t2_dc_once", n_dcr - s_dcr, 1);

        // Back-to-back reads with both caches continuously requesting
        do_reset();
        ic_rreq_valid = 1; ic_rreq_addr = 32'h0000_5000;
        dc_rreq_valid = 1; dc_rreq_addr = 32'h0000_6000;
        mem_ar_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("t3_grant%0d", i), {ic_rreq_ready, dc_rreq_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i > 0) begin
                d = {4{32'hC0DE_0000 + 32'(i - 1)}};
                check_eq($sformatf("t3_resp%0d", i - 1), {ic_rresp_valid, dc_rresp_valid}, (i % 2 == 0) ? 2'b01 : 2'b10);
                check_eq($sformatf("t3_data%0d", i - 1), (i % 2 == 0) ? dc_rresp_data : ic_rresp_data, d);
            end
            step();
            @(negedge clk);
            check_eq($sformatf("t3_ar_addr%0d", i), mem_ar_addr, (i % 2 == 0) ? 32'h0000_5000 : 32'h0000_6000);
            step(); mem_r_valid = 1; mem_r_data = {4{32'hC0DE_0000 + 32'(i)}};
            step(); mem_r_valid = 0;
        end
        ic_rreq_valid = 0; dc_rreq_valid = 0;
        @(negedge clk);
        check_eq("t3_resp3", {ic_rresp_valid, dc_rresp_valid, ic_rreq_ready, dc_rreq_ready}, 4'b0100);
        check_eq("t3_data3", dc_rresp_data, {4{32'hC0DE_0003}});

        // Address channel stalled for five cycles
        do_reset();
        s_ar = n_ar;
        ic_rreq_valid = 1; ic_rreq_addr = 32'h0000_7ABC;
        @(negedge clk);
        check_eq("t4_grant", ic_rreq_ready, 1);
        step(); ic_rreq_valid = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq($sformatf("t4_stall%0d", k), {mem_ar_valid, mem_ar_addr}, {1'b1, 32'h0000_7AB0});
            step();
        end
        mem_ar_ready = 1;
        @(negedge clk);
        check_eq("t4_hs_vld", mem_ar_valid, 1);
        step(); mem_ar_ready = 0;
        @(negedge clk);
        check_eq("t4_ar_drop", mem_ar_valid, 0);
        step();
        check_eq("t4_one_hs", n_ar - s_ar, 1);

        // Reset while waiting for read data, then a late response arrives
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_inrst");
        step();
        rst_n = 1'b1; mem_r_valid = 1; mem_r_data = {4{32'hFFFF_FFFF}}; mem_b_valid = 1;
        @(negedge clk);
        check_eq("t5_stray_vld", {mem_ar_valid, mem_aw_valid, ic_rresp_valid, dc_rresp_valid}, 0);
        step(); mem_r_valid = 0; mem_b_valid = 0;
        @(negedge clk);
        check_all_zero("t5_after");

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
        // Memory never answers: watchdog fires after eight wait cycles
        do_reset();
        ic_rreq_valid = 1; ic_rreq_addr = 32'h0000_0100; mem_ar_ready = 1;
        step(); ic_rreq_valid = 0;
        step(); mem_ar_ready = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_eq($sformatf("t6_wait%0d", k), {ic_rresp_valid, timeout_err}, 0);
            step();
        end
        @(negedge clk);
        check_eq("t6_tmo_vld", {ic_rresp_valid, timeout_err}, 2'b11);
        check_eq("t6_tmo_data", ic_rresp_data, '0);
        step(); step();
        @(negedge clk);
        check_eq("t6_sticky", {ic_rresp_valid, timeout_err}, 2'b01);
`else
        check_eq("t6_err_tied", timeout_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 128-bit line-wide memory port between the L1 I-cache (line refills only) and the L1 D-cache (line refills and write-backs).
- Allows one memory transaction in flight at a time and forwards each response to the requester that issued it.
- Sits between both cache controllers and the memory/bus model, using the cache package widths (32-bit address, 128-bit line, 16-bit byte mask).

Parameters:
- ADDR_WIDTH, 32, address width.
- LINE_WIDTH, 128, memory data width, one cache line.
- OFFSET_WIDTH, 4, line offset bits, forced to zero on outgoing addresses.
- TIMEOUT_CYCLES, 255, watchdog limit (used only with the optional feature).

Ports:
- clk in 1: clock
- rst_n in 1: asynchronous active-low reset
- ic_rreq_valid in 1, ic_rreq_ready out 1, ic_rreq_addr in 32: I-cache refill request
- ic_rresp_valid out 1, ic_rresp_data out 128: I-cache refill data
- dc_rreq_valid in 1, dc_rreq_ready out 1, dc_rreq_addr in 32: D-cache refill request
- dc_rresp_valid out 1, dc_rresp_data out 128: D-cache refill data
- dc_wreq_valid in 1, dc_wreq_ready out 1, dc_wreq_addr in 32, dc_wreq_data in 128, dc_wreq_wmask in 16: D-cache write-back
- dc_wresp_valid out 1: write-back complete
- mem_ar_valid out 1, mem_ar_ready in 1, mem_ar_addr out 32: memory read address
- mem_r_valid in 1, mem_r_data in 128, mem_r_resp in 2: memory read data
- mem_aw_valid out 1, mem_aw_ready in 1, mem_aw_addr out 32, mem_w_data out 128, mem_w_wmask out 16: memory write
- mem_b_valid in 1, mem_b_resp in 2: memory write response
- timeout_err out 1: sticky watchdog flag

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low. On reset, every output is 0, the FSM is in IDLE, and the round-robin pointer favours the I-cache.
- FSM states: IDLE, RD_ADDR, RD_WAIT, WR_ADDR, WR_WAIT. An owner register records the owner of the current transaction (IC or DC).
- IDLE arbitration, evaluated combinationally each cycle:
  - dc_wreq has fixed highest priority, so a write-back always precedes a refill.
  - Otherwise ic_rreq and dc_rreq are granted round-robin. The pointer toggles to favour the other requester after each read grant.
- Grant: the winner's *_ready is high for exactly that IDLE cycle, combinational with its valid. Address, data and wmask are registered at that edge. The FSM goes to WR_ADDR or RD_ADDR. Losers see ready = 0 and must hold valid.
- Address alignment: mem_ar_addr and mem_aw_addr carry the registered address with bits [3:0] forced to 0. mem_w_wmask passes through unchanged.
- RD_ADDR: mem_ar_valid = 1 until mem_ar_ready is sampled high, then go to RD_WAIT. Address stays stable while valid is high.
- RD_WAIT: on mem_r_valid, register mem_r_data into the owner's *_rresp_data. Pulse the owner's *_rresp_valid for 1 cycle in the next cycle. Go to IDLE.
- WR_ADDR: mem_aw_valid = 1 with data and mask until mem_aw_ready, then go to WR_WAIT. On mem_b_valid, pulse dc_wresp_valid the next cycle and go to IDLE.
- Response timing: the response pulse and a new grant may occur in the same IDLE cycle.
  - Minimum read turnaround: grant(T), ar handshake(T+1), r_valid(T+2), rresp_valid(T+3).
- Non-owner data outputs hold their previous value. mem_r_resp and mem_b_resp are ignored unless the optional feature is enabled.
- Stray inputs: mem_r_valid or mem_b_valid arriving in IDLE, or in the wrong state, are ignored.
- Reset mid-transaction: the FSM returns to IDLE and all valids drop immediately. Late memory responses are then ignored per the stray-input rule.
- No requests: the FSM stays in IDLE and all mem_*_valid stay 0.

Optional Feature:
- Macro MEM_PORT_ARBITER_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to RD_WAIT or WR_WAIT and increments each cycle spent there.
  - When the count reaches TIMEOUT_CYCLES, the owner's response pulses with data 0 and the FSM returns to IDLE.
  - timeout_err sets and stays set until reset.
  - A nonzero mem_r_resp or mem_b_resp also sets timeout_err; the response is still delivered.
- Undefined: no counter, timeout_err tied to 0, and the FSM waits indefinitely.

Test Plan:
- I-cache read alone: ic_rreq_addr=0x0000_1234, mem ready immediate, mem_r_data=0xA5..A5 two cycles later -> mem_ar_addr=0x0000_1230; ic_rresp_valid one 1-cycle pulse carrying 0xA5..A5; dc_rresp_valid stays 0.
- All three requests valid in the same cycle -> grant order is dc_wreq (aw_addr=dc addr, wmask=0xFFFF), then ic_rreq, then dc_rreq. Each *_ready pulses exactly once.
- Back-to-back reads with ic and dc both continuously valid, 4 transactions -> grants alternate IC, DC, IC, DC.
- mem_ar_ready held low for 5 cycles -> mem_ar_valid and mem_ar_addr stay stable for all 5 cycles; no duplicate handshake.
- rst_n asserted during RD_WAIT, then mem_r_valid arrives after release -> all outputs 0; no rresp pulse; FSM in IDLE.
- With TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never responds -> owner rresp_valid pulses with data 0 after 8 wait cycles; timeout_err=1 and stays set.
